// File: rtl/sprite_compositor.sv
// Bouncing-sprite animation and priority compositor for the 640x480 VGA path.
// Define SPR_COLLIDE_EN to build the per-frame sprite overlap flags on o_collide.
module sprite_compositor #(
  parameter int NUM_SPR = 4,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int HALF    = 40,
  parameter int STEP    = 1,
  parameter int COORD_W = 12
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_stb,
  input  logic               i_animate,
  input  logic [9:0]         i_x,
  input  logic [8:0]         i_y,
  input  logic               i_wr_en,
  input  logic [2:0]         i_wr_idx,
  input  logic [COORD_W-1:0] i_wr_x,
  input  logic [COORD_W-1:0] i_wr_y,
  input  logic [11:0]        i_wr_rgb,
  output logic [11:0]        o_rgb,
  output logic               o_hit,
  output logic [2:0]         o_id,
  output logic [NUM_SPR-1:0] o_collide
);

  function automatic logic [COORD_W-1:0] init_pos(input int i, input int res);
    return COORD_W'((i + 1) * res / (NUM_SPR + 1));
  endfunction

  function automatic logic [11:0] init_rgb(input int i);
    case (i % 3)
      0:       return 12'hF00;
      1:       return 12'h0F0;
      default: return 12'h00F;
    endcase
  endfunction

  // Returns {new_dir, new_centre}; the bounce reverses and steps back in one frame.
  function automatic logic [COORD_W:0] step_axis(input logic [COORD_W-1:0] c,
                                                 input logic d, input int res);
    int   cv;
    logic nd;
    cv = int'(c);
    nd = d;
    if (d && (cv + HALF + STEP > res - 1)) begin
      nd = 1'b0;
      cv = cv - STEP;
    end else if (!d && (cv < HALF + STEP)) begin
      nd = 1'b1;
      cv = cv + STEP;
    end else if (d) begin
      cv = cv + STEP;
    end else begin
      cv = cv - STEP;
    end
    return {nd, COORD_W'(cv)};
  endfunction

  function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] v,
                                               input int lo, input int hi);
    if (int'(v) < lo) return COORD_W'(lo);
    if (int'(v) > hi) return COORD_W'(hi);
    return v;
  endfunction

  logic [COORD_W-1:0] r_cx  [NUM_SPR];
  logic [COORD_W-1:0] r_cy  [NUM_SPR];
  logic [11:0]        r_rgb [NUM_SPR];
  logic [NUM_SPR-1:0] r_dx, r_dy;
  logic [NUM_SPR-1:0] r_hit;

  logic [NUM_SPR-1:0] w_hit, w_wr_sel;
  logic               w_move;
  logic [2:0]         w_id;
  logic [11:0]        w_rgb;

  assign w_move = i_animate & i_pix_stb;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_hit    = '0;
    w_wr_sel = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      w_wr_sel[i] = i_wr_en && (i_wr_idx == 3'(i));
      w_hit[i] = (int'(i_x) > int'(r_cx[i]) - HALF) && (int'(i_x) < int'(r_cx[i]) + HALF) &&
                 (int'(i_y) > int'(r_cy[i]) - HALF) && (int'(i_y) < int'(r_cy[i]) + HALF);
    end
  end

  // Walk high to low so the lowest-index hit is the last assignment and wins.
  always_comb begin
    w_id  = '0;
    w_rgb = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (r_hit[i]) begin
        w_id  = 3'(i);
        w_rgb = r_rgb[i];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the sprite table is a handful of flops, not a RAM, so it is reset like any register.
      for (int i = 0; i < NUM_SPR; i++) begin
        r_cx[i]  <= init_pos(i, H_RES);
        r_cy[i]  <= init_pos(i, V_RES);
        r_rgb[i] <= init_rgb(i);
        r_dx[i]  <= 1'b1;
        r_dy[i]  <= (i % 2 == 0);
      end
    end else begin
      for (int i = 0; i < NUM_SPR; i++) begin
        if (w_wr_sel[i]) begin
          r_cx[i]  <= clamp(i_wr_x, HALF, H_RES - 1 - HALF);
          r_cy[i]  <= clamp(i_wr_y, HALF, V_RES - 1 - HALF);
          r_rgb[i] <= i_wr_rgb;
        end else if (w_move) begin
          // NOTE: non-blocking updates keep every sprite stepping from the same pre-edge state.
          {r_dx[i], r_cx[i]} <= step_axis(r_cx[i], r_dx[i], H_RES);
          {r_dy[i], r_cy[i]} <= step_axis(r_cy[i], r_dy[i], V_RES);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hit <= '0;
      o_rgb <= '0;
      o_hit <= 1'b0;
      o_id  <= '0;
    end else if (i_pix_stb) begin
      r_hit <= w_hit;
      o_rgb <= w_rgb;
      o_hit <= |r_hit;
      o_id  <= w_id;
    end
  end

`ifdef SPR_COLLIDE_EN
  logic [NUM_SPR-1:0] r_acc;
  logic [NUM_SPR-1:0] w_coll;

  assign w_coll = ($countones(r_hit) > 1) ? r_hit : '0;

  // The snapshot includes overlaps seen on the animate strobe itself.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc     <= '0;
      o_collide <= '0;
    end else if (i_pix_stb) begin
      if (i_animate) begin
        o_collide <= r_acc | w_coll;
        r_acc     <= '0;
      end else begin
        r_acc <= r_acc | w_coll;
      end
    end
  end
`else
  assign o_collide = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor (NUM_SPR=4): pixel probes, writes, bounce, clamp, priority, reset.
module tb_sprite_compositor;

  logic        clk = 1'b0;
  logic        i_rst, i_pix_stb, i_animate, i_wr_en;
  logic [9:0]  i_x;
  logic [8:0]  i_y;
  logic [2:0]  i_wr_idx;
  logic [11:0] i_wr_x, i_wr_y, i_wr_rgb;
  logic [11:0] o_rgb;
  logic        o_hit;
  logic [2:0]  o_id;
  logic [3:0]  o_collide;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SPR_COLLIDE_EN
  localparam logic [3:0] COLL_01 = 4'b0011;
`else
  localparam logic [3:0] COLL_01 = 4'b0000;
`endif

  typedef struct {
    int          x;
    int          y;
    logic        hit;
    logic [2:0]  id;
    logic [11:0] rgb;
  } pix_vec_t;

  pix_vec_t reset_tbl[15];

  sprite_compositor dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_pix_stb (i_pix_stb),
    .i_animate (i_animate),
    .i_x       (i_x),
    .i_y       (i_y),
    .i_wr_en   (i_wr_en),
    .i_wr_idx  (i_wr_idx),
    .i_wr_x    (i_wr_x),
    .i_wr_y    (i_wr_y),
    .i_wr_rgb  (i_wr_rgb),
    .o_rgb     (o_rgb),
    .o_hit     (o_hit),
    .o_id      (o_id),
    .o_collide (o_collide)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic strobe();
    @(negedge clk);
    i_pix_stb = 1'b1;
    @(negedge clk);
    i_pix_stb = 1'b0;
  endtask

  task automatic probe(input int x, input int y);
    @(negedge clk);
    i_x = 10'(x);
    i_y = 9'(y);
    strobe();
    strobe();
  endtask

  task automatic check_pix(input string nm, input int x, input int y,
                           input logic h, input logic [2:0] id, input logic [11:0] rgb);
    probe(x, y);
    check({nm, "_hit"}, 32'(o_hit), 32'(h));
    check({nm, "_id"},  32'(o_id),  32'(id));
    check({nm, "_rgb"}, 32'(o_rgb), 32'(rgb));
  endtask

  task automatic write_spr(input int idx, input int x, input int y, input logic [11:0] rgb,
                           input logic with_animate);
    @(negedge clk);
    i_wr_en   = 1'b1;
    i_wr_idx  = 3'(idx);
    i_wr_x    = 12'(x);
    i_wr_y    = 12'(y);
    i_wr_rgb  = rgb;
    i_animate = with_animate;
    i_pix_stb = with_animate;
    @(negedge clk);
    i_wr_en   = 1'b0;
    i_animate = 1'b0;
    i_pix_stb = 1'b0;
  endtask

  task automatic animate();
    @(negedge clk);
    i_animate = 1'b1;
    i_pix_stb = 1'b1;
    @(negedge clk);
    i_animate = 1'b0;
    i_pix_stb = 1'b0;
  endtask

  task automatic run_reset_table(input string tag);
    for (int i = 0; i < 15; i++)
      check_pix($sformatf("%s%0d", tag, i), reset_tbl[i].x, reset_tbl[i].y,
                reset_tbl[i].hit, reset_tbl[i].id, reset_tbl[i].rgb);
  endtask

  task automatic check_zero_outputs(input string nm);
    check({nm, "_rgb"},     32'(o_rgb),     32'h0);
    check({nm, "_hit"},     32'(o_hit),     32'h0);
    check({nm, "_id"},      32'(o_id),      32'h0);
    check({nm, "_collide"}, 32'(o_collide), 32'h0);
  endtask

  initial begin
    // Reset centres: s0 (128,96) s1 (256,192) s2 (384,288) s3 (512,384); edges are exclusive at +-40.
    reset_tbl[0]  = '{128,  96, 1'b1, 3'd0, 12'hF00};
    reset_tbl[1]  = '{ 88,  96, 1'b0, 3'd0, 12'h000};
    reset_tbl[2]  = '{ 89,  96, 1'b1, 3'd0, 12'hF00};
    reset_tbl[3]  = '{167,  96, 1'b1, 3'd0, 12'hF00};
    reset_tbl[4]  = '{168,  96, 1'b0, 3'd0, 12'h000};
    reset_tbl[5]  = '{128,  56, 1'b0, 3'd0, 12'h000};
    reset_tbl[6]  = '{128,  57, 1'b1, 3'd0, 12'hF00};
    reset_tbl[7]  = '{128, 135, 1'b1, 3'd0, 12'hF00};
    reset_tbl[8]  = '{128, 136, 1'b0, 3'd0, 12'h000};
    reset_tbl[9]  = '{256, 192, 1'b1, 3'd1, 12'h0F0};
    reset_tbl[10] = '{256, 152, 1'b0, 3'd0, 12'h000};
    reset_tbl[11] = '{384, 288, 1'b1, 3'd2, 12'h00F};
    reset_tbl[12] = '{512, 384, 1'b1, 3'd3, 12'hF00};
    reset_tbl[13] = '{  0,   0, 1'b0, 3'd0, 12'h000};
    reset_tbl[14] = '{300, 300, 1'b0, 3'd0, 12'h000};

    i_rst = 1'b1; i_pix_stb = 1'b0; i_animate = 1'b0; i_wr_en = 1'b0;
    i_x = '0; i_y = '0; i_wr_idx = '0; i_wr_x = '0; i_wr_y = '0; i_wr_rgb = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("rst");
    i_rst = 1'b0;

    run_reset_table("tbl");

    // Latency: a hit shows only after the second strobe and then holds without strobes.
    probe(0, 0);
    @(negedge clk);
    i_x = 10'd128;
    i_y = 9'd96;
    strobe();
    check("lat_stb1_hit", 32'(o_hit), 32'h0);
    strobe();
    check("lat_stb2_hit", 32'(o_hit), 32'h1);
    check("lat_stb2_rgb", 32'(o_rgb), 32'hF00);
    repeat (5) @(negedge clk);
    check("hold_hit", 32'(o_hit), 32'h1);

    // Right-edge bounce for sprite 2 and coordinate clamping.
    write_spr(2, 599, 300, 12'h00F, 1'b0);
    check_pix("s2_pre", 638, 300, 1'b1, 3'd2, 12'h00F);
    check_pix("s2_pre_out", 639, 300, 1'b0, 3'd0, 12'h000);
    animate();
    check("coll_frame1", 32'(o_collide), 32'h0);
    check_pix("s2_bnc_r_out", 638, 301, 1'b0, 3'd0, 12'h000);
    check_pix("s2_bnc_r_in", 637, 301, 1'b1, 3'd2, 12'h00F);
    check_pix("s2_bnc_l_in", 559, 301, 1'b1, 3'd2, 12'h00F);
    check_pix("s2_bnc_l_out", 558, 301, 1'b0, 3'd0, 12'h000);
    write_spr(2, 700, 0, 12'h00F, 1'b0);
    check_pix("clamp_x_in", 638, 40, 1'b1, 3'd2, 12'h00F);
    check_pix("clamp_x_out", 639, 40, 1'b0, 3'd0, 12'h000);
    check_pix("clamp_y_top", 638, 1, 1'b1, 3'd2, 12'h00F);
    check_pix("clamp_y_zero", 638, 0, 1'b0, 3'd0, 12'h000);
    check_pix("clamp_y_bot", 638, 79, 1'b1, 3'd2, 12'h00F);
    check_pix("clamp_y_out", 638, 80, 1'b0, 3'd0, 12'h000);

    // Coincident sprites 0 and 1: lowest index wins and the overlap is flagged.
    write_spr(0, 200, 200, 12'hF00, 1'b0);
    write_spr(1, 200, 200, 12'h0F0, 1'b0);
    check_pix("prio", 200, 200, 1'b1, 3'd0, 12'hF00);
    animate();
    check("coll_frame2", 32'(o_collide), 32'(COLL_01));

    // Index beyond NUM_SPR must not touch any sprite.
    write_spr(4, 400, 400, 12'hFFF, 1'b0);
    check_pix("bad_idx_none", 400, 400, 1'b0, 3'd0, 12'h000);
    check_pix("bad_idx_s0", 201, 201, 1'b1, 3'd0, 12'hF00);

    // Write to sprite 1 in the animate cycle: s1 takes the write, s0 steps to (202,202).
    write_spr(1, 300, 300, 12'h0F0, 1'b1);
    check("coll_frame3", 32'(o_collide), 32'(COLL_01));
    check_pix("wm_s1_r_in", 339, 300, 1'b1, 3'd1, 12'h0F0);
    check_pix("wm_s1_r_out", 340, 300, 1'b0, 3'd0, 12'h000);
    check_pix("wm_s1_l_in", 261, 300, 1'b1, 3'd1, 12'h0F0);
    check_pix("wm_s1_l_out", 260, 300, 1'b0, 3'd0, 12'h000);
    check_pix("wm_s0_r_in", 241, 202, 1'b1, 3'd0, 12'hF00);
    check_pix("wm_s0_r_out", 242, 202, 1'b0, 3'd0, 12'h000);
    check_pix("wm_s0_t_in", 202, 163, 1'b1, 3'd0, 12'hF00);
    check_pix("wm_s0_t_out", 202, 162, 1'b0, 3'd0, 12'h000);

    // Asynchronous reset with a hit in flight.
    check_pix("pre_rst", 300, 300, 1'b1, 3'd1, 12'h0F0);
    @(negedge clk);
    i_x = 10'd202;
    i_y = 9'd202;
    strobe();
    #2 i_rst = 1'b1;
    #1 check_zero_outputs("async_rst");
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    i_x = 10'd128;
    i_y = 9'd96;
    strobe();
    check("post_rst_pipe", 32'(o_hit), 32'h0);
    strobe();
    check("post_rst_hit", 32'(o_hit), 32'h1);
    run_reset_table("post");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
